// File: rtl/cosine_vec_loader_if.sv
// Signal bundle between the vector loader and its environment: input beat
// stream, register banks and start pulse to the engine, engine result, result port.
interface cosine_vec_loader_if #(
  parameter int W  = 5,
  parameter int DW = 32
);
  localparam int LW = $clog2(W + 1);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high. A source holding valid keeps its data stable until that edge;
  // ready never depends combinationally on valid.
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_a;
  logic [DW-1:0]        in_b;
  logic                 in_last;

  logic [W-1:0][DW-1:0] vec_a;
  logic [W-1:0][DW-1:0] vec_b;
  logic                 start;
  logic                 sim_valid;
  logic [DW-1:0]        sim_data;

  logic                 res_valid;
  logic                 res_ready;
  logic [DW-1:0]        res_data;
  logic [LW-1:0]        res_len;
  logic                 res_ovf;
  logic                 res_tmo;

  modport master (
    output in_valid, in_a, in_b, in_last, sim_valid, sim_data, res_ready,
    input  in_ready, vec_a, vec_b, start, res_valid, res_data, res_len,
           res_ovf, res_tmo
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, sim_valid, sim_data, res_ready,
    output in_ready, vec_a, vec_b, start, res_valid, res_data, res_len,
           res_ovf, res_tmo
  );
endinterface

// File: rtl/cosine_vec_loader.sv
// Sequencer for cosine_sim: assembles element pairs into the vec_a/vec_b banks,
// pulses start, waits (bounded) for the engine and presents the similarity.
module cosine_vec_loader #(
  parameter int W       = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  cosine_vec_loader_if.slave   bus,
  output logic [2:0]           dbg_state
);
  localparam int LW = $clog2(W + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    DRAIN = 3'd1,
    FIRE  = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [LW-1:0]        idx;
  logic [LW-1:0]        len_q;
  logic [CW-1:0]        tmo_cnt;
  logic [W-1:0][DW-1:0] vec_a_q, vec_b_q;
  logic [DW-1:0]        res_data_q;
  logic                 in_ready_q;
  logic                 start_q;
  logic                 res_valid_q;
  logic                 ovf_q;
  logic                 tmo_q;
  logic                 in_xfer;
  logic                 res_xfer;
  logic                 tmo_hit;

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign res_xfer = res_valid_q && bus.res_ready;
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      LOAD: begin
        if (in_xfer) begin
          if (bus.in_last)                state_n = FIRE;
          else if (idx == LW'(W - 1))     state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (in_xfer && bus.in_last)       state_n = FIRE;
      end
      FIRE:                               state_n = WAIT;
      WAIT: begin
        if (bus.sim_valid || tmo_hit)     state_n = OUT;
      end
      OUT: begin
        if (res_xfer)                     state_n = LOAD;
      end
      default:                            state_n = LOAD;
    endcase
  end

  // Handshake and strobe outputs are registered from the next state so they
  // line up with the state they belong to and never see an input combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= '0;
      len_q       <= '0;
      tmo_cnt     <= '0;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      res_data_q  <= '0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state       <= state_n;
      in_ready_q  <= (state_n == LOAD) || (state_n == DRAIN);
      start_q     <= (state_n == FIRE);
      res_valid_q <= (state_n == OUT);

      case (state)
        LOAD: begin
          if (in_xfer) begin
            for (int i = 0; i < W; i++) begin
              if (idx == LW'(i)) begin
                vec_a_q[i] <= bus.in_a;
                vec_b_q[i] <= bus.in_b;
              end
            end
            idx   <= idx + LW'(1);
            len_q <= idx + LW'(1);
            if (!bus.in_last && (idx == LW'(W - 1))) ovf_q <= 1'b1;
          end
        end
        FIRE: begin
          tmo_cnt <= '0;
        end
        WAIT: begin
          if (bus.sim_valid) begin
            res_data_q <= bus.sim_data;
            tmo_q      <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
            if (tmo_hit) begin
              res_data_q <= '0;
              tmo_q      <= 1'b1;
            end
          end
        end
        OUT: begin
          // Zeroed banks are what lets short vectors read as zero-padded.
          if (res_xfer) begin
            vec_a_q <= '0;
            vec_b_q <= '0;
            idx     <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.vec_a     = vec_a_q;
  assign bus.vec_b     = vec_b_q;
  assign bus.start     = start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_len   = len_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.res_tmo   = tmo_q;
  assign dbg_state     = state;
endmodule
